// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and helpers for the 7-segment scan controller
// Purpose: register map, CTRL field positions, scan state type and "all off" output codes.
// Ports: none (package).
package seg7_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MASK_LSB = 4;
  localparam int CTRL_MASK_MSB = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Active-low one-hot digit enable for digit d.
  function automatic logic [3:0] dig_sel_n(input logic [1:0] d);
    dig_sel_n = ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/seg7_dwell_timer.sv
// rtl/seg7_dwell_timer.sv - loadable down-counter with terminal-count flag
// Purpose: times both the digit dwell and the inter-digit blanking guard.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (count -> 0)
//   load_i       load load_val_i (has priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one; holds at zero
//   tc_o         count is zero
module seg7_dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - Avalon-MM 4-digit multiplexed 7-segment scan controller
// Purpose: register file (DATA/CTRL/DIVIDER/STATUS) plus IDLE/BLANK/DRIVE scanner
//   with a blanking guard between digits and frame-boundary data shadowing.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   address, chipselect, write_n,   Avalon-MM slave; readdata is combinational
//   writedata, readdata
//   seg_n [7:0]                     {dp,g,f,e,d,c,b,a}, active-low, registered
//   dig_n [3:0]                     digit enables, active-low, registered
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIV_RESET    = 50000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_n
);

  localparam logic [1:0]  LAST_DIGIT = 2'(DIGITS - 1);
  localparam logic [15:0] GUARD_M1   = 16'(GUARD_CYCLES - 1);

  logic [31:0] data_q;
  logic        ctrl_en_q;
  logic [3:0]  mask_q;
  logic [15:0] div_q;
  logic [31:0] shadow_q, shadow_d;
  state_e      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  seg_n_q, seg_n_d;
  logic [3:0]  dig_n_q, dig_n_d;

  logic        wr_en;
  logic        tmr_load, tmr_dec, tmr_tc;
  logic [15:0] tmr_val;
  logic [15:0] dwell_m1;

  assign wr_en = chipselect && !write_n;

  // DIVIDER=0 behaves as 1 so the dwell never underflows.
  assign dwell_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      ctrl_en_q <= 1'b0;
      mask_q    <= '0;
      div_q     <= 16'(DIV_RESET);
    end else if (wr_en) begin
      case (address)
        ADDR_DATA: data_q <= writedata;
        ADDR_CTRL: begin
          ctrl_en_q <= writedata[CTRL_EN_BIT];
          mask_q    <= writedata[CTRL_MASK_MSB:CTRL_MASK_LSB];
        end
        ADDR_DIV:  div_q <= writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA: readdata = data_q;
      ADDR_CTRL: readdata = {24'd0, mask_q, 3'd0, ctrl_en_q};
      ADDR_DIV:  readdata = {16'd0, div_q};
      default:   readdata = {29'd0, (state_q == DRIVE), digit_q};
    endcase
  end

  seg7_dwell_timer #(.WIDTH(16)) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    if (!ctrl_en_q) begin
      state_d  = IDLE;
      digit_d  = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          digit_d  = '0;
          shadow_d = data_q;
          tmr_load = 1'b1;
          tmr_val  = GUARD_M1;
        end
        BLANK: begin
          if (tmr_tc) begin
            state_d  = DRIVE;
            tmr_load = 1'b1;
            tmr_val  = dwell_m1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        DRIVE: begin
          if (tmr_tc) begin
            state_d  = BLANK;
            digit_d  = digit_q + 2'd1;
            tmr_load = 1'b1;
            tmr_val  = GUARD_M1;
            // Frame boundary: latch the live DATA so a frame never mixes old and new bytes.
            if (digit_q == LAST_DIGIT) begin
              shadow_d = data_q;
            end
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs follow the current state one clock later; enable and blank mask are
  // applied live so clearing them blanks on the very next update.
  always_comb begin
    seg_n_d = SEG_OFF;
    dig_n_d = DIG_OFF;
    if (ctrl_en_q && (state_q == DRIVE)) begin
      seg_n_d = ~shadow_q[{digit_q, 3'b000} +: 8];
      if (!mask_q[digit_q]) begin
        dig_n_d = dig_sel_n(digit_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      shadow_q <= '0;
      seg_n_q  <= SEG_OFF;
      dig_n_q  <= DIG_OFF;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      seg_n_q  <= seg_n_d;
      dig_n_q  <= dig_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dig_n = dig_n_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd3;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int n_vec = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  logic [7:0] lit_seg [4] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [3:0] lit_dig [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg7_scan_ctrl #(.DIGITS(4), .DIV_RESET(50000), .GUARD_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after the first enabled edge the scan is a pure function of n, the
  // number of edges since start: slot period P, digit = (n/P)%4, lit when n%P >= G.
  logic [31:0] m_data, m_shadow;
  logic        m_en;
  logic [3:0]  m_mask;
  logic [15:0] m_div;
  bit          m_run;
  int          m_n, m_p;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data <= '0; m_shadow <= '0; m_en <= 1'b0; m_mask <= '0; m_div <= 16'd50000;
      m_run <= 1'b0; m_n <= 0; m_p <= 1; exp_seg <= 8'hFF; exp_dig <= 4'hF;
    end else begin
      int d;
      d = (m_n / m_p) % 4;
      if (m_run && m_en && (m_n % m_p) >= G) begin
        exp_seg <= ~m_shadow[8*d +: 8];
        exp_dig <= m_mask[d] ? 4'hF : ~(4'b0001 << d);
      end else begin
        exp_seg <= 8'hFF;
        exp_dig <= 4'hF;
      end
      if (!m_en) begin
        m_run <= 1'b0;
        m_n   <= 0;
      end else if (!m_run) begin
        m_run    <= 1'b1;
        m_n      <= 0;
        m_p      <= ((m_div == 16'd0) ? 1 : int'(m_div)) + G;
        m_shadow <= m_data;
      end else begin
        m_n <= m_n + 1;
        if (((m_n + 1) % (4 * m_p)) == 0) m_shadow <= m_data;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data <= writedata;
          2'd1: begin m_en <= writedata[0]; m_mask <= writedata[7:4]; end
          2'd2: m_div <= writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd();
    case (address)
      2'd0: return m_data;
      2'd1: return {24'd0, m_mask, 3'd0, m_en};
      2'd2: return {16'd0, m_div};
      default: begin
        if (!m_run) return 32'd0;
        return {29'd0, ((m_n % m_p) >= G), 2'((m_n / m_p) % 4)};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_seg", {24'd0, seg_n}, {24'd0, exp_seg});
      check("model_dig", {28'd0, dig_n}, {28'd0, exp_dig});
      check("model_rd", readdata, exp_rd());
    end
  end

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  task automatic wait_dig(input string name, input logic [3:0] t);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dig_n === t) begin found = 1'b1; break; end
    end
    check({name, "_wait"}, {31'd0, found}, 32'd1);
  endtask

  // Literal frame start after enable: 4 dark samples, then 4 lit + 2 guard per digit.
  task automatic check_start(input string tag);
    logic [7:0] es;
    logic [3:0] ed;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      es = 8'hFF; ed = 4'hF;
      if (i >= 4 && ((i - 4) % 6) < 4) begin
        es = lit_seg[(i - 4) / 6];
        ed = lit_dig[(i - 4) / 6];
      end
      check({tag, "_seg"}, {24'd0, seg_n}, {24'd0, es});
      check({tag, "_dig"}, {28'd0, dig_n}, {28'd0, ed});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_seg", {24'd0, seg_n}, 32'hFF);
    check("rst_dig", {28'd0, dig_n}, 32'hF);
    rd_check("rst_data", 2'd0, 32'd0);
    rd_check("rst_ctrl", 2'd1, 32'd0);
    rd_check("rst_div", 2'd2, 32'd50000);
    rd_check("rst_stat", 2'd3, 32'd0);

    write_reg(2'd2, 32'd4);
    write_reg(2'd0, 32'h3F06_5B4F);
    write_reg(2'd1, 32'h1);
    check_start("scan");

    wait_dig("d1", 4'hD);
    write_reg(2'd0, 32'h0);
    wait_dig("d3", 4'h7);
    check("old_d3_seg", {24'd0, seg_n}, 32'hC0);
    wait_dig("d0", 4'hE);
    check("new_d0_seg", {24'd0, seg_n}, 32'hFF);

    write_reg(2'd0, 32'h3F06_5B4F);
    write_reg(2'd1, 32'h41);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dig_n === 4'hB) cnt++;
    end
    check("mask_no_d2", cnt, 32'd0);
    wait_dig("m_d1", 4'hD);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dig_n !== 4'hD) break;
      cnt++;
    end
    check("d1_dwell", cnt, 32'd4);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      if (dig_n === 4'h7) break;
      @(negedge clk);
      if (dig_n !== 4'h7) cnt++;
    end
    check("masked_gap", cnt, 32'd8);

    write_reg(2'd1, 32'h1);
    wait_dig("dis_d3", 4'h7);
    write_reg(2'd1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("dis_seg", {24'd0, seg_n}, 32'hFF);
    check("dis_dig", {28'd0, dig_n}, 32'hF);
    rd_check("dis_stat", 2'd3, 32'd0);
    write_reg(2'd1, 32'h1);
    check_start("reen");

    write_reg(2'd1, 32'h0);
    write_reg(2'd2, 32'h0);
    write_reg(2'd1, 32'h1);
    wait_dig("div0", 4'hE);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dig_n !== 4'hE) break;
      cnt++;
    end
    check("div0_dwell", cnt, 32'd1);

    @(posedge clk); #1 address = 2'd2;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dig_n !== 4'hF) begin cnt = 1; break; end
    end
    check("pre_rst_drive", cnt, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_seg", {24'd0, seg_n}, 32'hFF);
    check("arst_dig", {28'd0, dig_n}, 32'hF);
    check("arst_div", readdata, 32'd50000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Avalon-MM slave that configures and sequences a time-multiplexed 7-segment display: 4 digits, common-digit-enable, active-low segments and digit enables.
- Sits beside the Nios system's PIO peripherals on the system interconnect.
- Software writes raw segment bytes and control fields.
- The block scans the digits with a programmable dwell time, inserts a blanking guard between digits against ghosting, and loads new data only at frame boundaries so a frame never tears.

Parameters:
- DIGITS, 4: number of scanned digits; fixed at 4 for this revision; the DATA register packs one byte per digit.
- DIV_RESET, 50000: reset value of the DIVIDER register, in clk cycles per digit dwell (1 kHz/digit at 50 MHz).
- GUARD_CYCLES, 8: blanking clk cycles between consecutive digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- seg_n  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- dig_n  out  4  digit enables, active-low; bit i = digit i.

Behaviour:
- Registers, written when chipselect && !write_n:
  - addr 0 DATA[31:0]: byte i = segment pattern of digit i, 1 = lit.
  - addr 1 CTRL: bit0 enable; bits[7:4] blank mask, 1 = digit suppressed.
  - addr 2 DIVIDER[15:0]; upper bits read as 0.
  - addr 3 STATUS, read-only: bits[1:0] current digit; bit2 = state is DRIVE; writes ignored.
- Reset values: DATA=0, CTRL=0, DIVIDER=DIV_RESET, shadow=0, digit=0, state IDLE, counter=0.
- Outputs during reset: seg_n=8'hFF, dig_n=4'hF.
- Outputs are registered; they change one clk after a state/digit change.
- readdata is a combinational mux of the addressed register. It reads the live DATA, not the shadow.
- State machine IDLE / BLANK / DRIVE:
  - IDLE: outputs off. Entered when enable=0. On enable=1, load shadow<=DATA, digit<=0, counter<=GUARD_CYCLES-1, go to BLANK.
  - BLANK: seg_n=FF, dig_n=F. Count down. At 0, load counter<=max(DIVIDER,1)-1 and go to DRIVE.
  - DRIVE: seg_n=~shadow[digit], dig_n has only bit digit low unless blank mask[digit]=1 (then dig_n=F; the slot is still consumed). Count down. At 0, go to BLANK with counter<=GUARD_CYCLES-1 and digit<=digit+1 mod 4.
  - When digit wraps from 3 to 0, shadow<=DATA in that same cycle.
- Per-digit period = max(DIVIDER,1)+GUARD_CYCLES clk cycles; frame period = 4x that.
- DIVIDER=0 is treated as 1.
- A DIVIDER write mid-dwell takes effect at the next DRIVE load; the current dwell is not truncated.
- A DATA write mid-frame is not displayed until the next wrap.
- A CTRL blank-mask write takes effect immediately on the next output register update.
- enable 1->0 at any state: next cycle state=IDLE, outputs off, digit=0. Re-enable restarts from BLANK, digit 0.
- Simultaneous DATA write and wrap in the same cycle: shadow loads the old DATA; the new value appears next frame.
- Asynchronous reset mid-scan forces reset values immediately, with no glitch pulse on dig_n.

Decomposition:
- Shared package seg7_pkg:
  - register address constants (ADDR_DATA=0, ADDR_CTRL=1, ADDR_DIV=2, ADDR_STAT=3)
  - CTRL bit positions
  - state enum {IDLE, BLANK, DRIVE}
  - SEG_OFF=8'hFF, DIG_OFF=4'hF
- One sub-module is natural: seg7_dwell_timer, a loadable down-counter with a terminal-count flag, used for both dwell and guard.
- The register file and FSM stay in the top level.

Test Plan:
- Reset held, then released with no writes -> seg_n=FF, dig_n=F indefinitely; reads return DATA=0, CTRL=0, DIVIDER=50000, STATUS=0.
- DIVIDER=4, DATA=32'h3F06_5B4F, CTRL=1, GUARD_CYCLES=2 -> BLANK 2 cycles, then:
  - digit0: dig_n=E, seg_n=B0 for 4 cycles
  - digit1: dig_n=D, seg_n=A4
  - digit2: dig_n=B, seg_n=F9
  - digit3: dig_n=7, seg_n=C0
  - 6-cycle per-digit spacing, repeating.
- Write DATA=32'h0000_0000 while digit1 is driving -> digits 1..3 still show the old bytes; from digit0 of the next frame seg_n=FF.
- CTRL=32'h0000_0041 (enable, mask digit2) -> dig_n never equals B; the digit2 slot still lasts 4+2 cycles; the other digits are unchanged.
- enable cleared during DRIVE of digit 3 -> next cycle IDLE, outputs off, STATUS=0. Re-enable -> first DRIVE is digit 0 after 2 guard cycles.
- DIVIDER=0 -> each DRIVE lasts exactly 1 cycle. Assert reset mid-DRIVE -> outputs FF/F on the same edge; DIVIDER reads 50000.
